rr_mux8_arbiter: RTL and testbench
==================================

Name: rr_mux8_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 8:1 single-bit mux path among 8 requesters. It grants one requester at a time for a bounded burst, drives the mux select, and forwards the granted requester's data bit to a single shared output. Sits in front of the shared serial sink so that no requester can starve the others.

Parameters:
MAX_BURST, 4, maximum consecutive grant cycles per winner; legal range 1..15; internal burst counter is 4 bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous and active-high
en  input  1  global arbitration enable
req  input  8  request bit per requester; level-sensitive, held while the requester wants the path
in  input  8  data bit per requester; in[i] belongs to req[i]
gnt  output  8  registered one-hot grant; 0 when no owner
sel  output  3  registered mux select, equal to the index of the granted requester
valid  output  1  combinational, (state==GRANT) & req[sel]
out  output  1  combinational, in[sel] when valid, else 0
done  output  1  registered one-cycle pulse in the cycle after a grant is released

Behaviour:
- Reset (rst=1 at edge): state=IDLE, gnt=0, sel=0, cnt=0, ptr=0, done=0. Consequently valid=0 and out=0. rst overrides every other input, including mid-burst.
- ptr (3 bits) is the highest-priority index. Search order is ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod-8 wrap). The winner is the first index in that order with req set.
- IDLE: if en=1 and |req, then at the next edge state=GRANT, sel=winner, gnt=1<<winner, cnt=1. Otherwise remain IDLE with gnt=0. Latency from request to grant is one cycle.
- GRANT: sel and gnt are held. The release condition is evaluated each cycle: req[sel]==0 OR cnt==MAX_BURST OR en==0.
  - No release: cnt increments by 1.
  - Release: ptr←sel+1 (7 wraps to 0) and done←1 at that edge. Re-arbitration happens in the same cycle using the new ptr and current req, so the releasing owner has the lowest priority.
    - en=1 and a winner exists: stay in GRANT with the new sel/gnt and cnt=1. There are no dead cycles.
    - Otherwise: go to IDLE with gnt=0.
- done is 0 in every cycle that does not follow a release edge.
- A sole requester that stays asserted is re-granted back-to-back. gnt is unchanged, done pulses every MAX_BURST cycles, and ptr advances each time.
- A cycle in GRANT where req[sel] has just dropped shows gnt still asserted but valid=0 and out=0. The grant releases at the end of that cycle.
- MAX_BURST=1 gives a new arbitration every cycle. cnt never exceeds MAX_BURST.
- Requests that assert or deassert for non-owners during a burst have no effect until the next arbitration.
- en=0 blocks new grants from IDLE and forces release at the end of the current GRANT cycle.
- out is purely combinational from in[sel], so there is zero data latency. sel changes only at edges.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=8'hFF, en=1 -> gnt=0, sel=0, valid=0, out=0, done=0. After rst falls, the first grant is gnt=8'h01.
- Sole requester: en=1, req=8'h08 held for 10 cycles, MAX_BURST=4 -> gnt=8'h08 from cycle 1 onward without gaps. done pulses after cycles 4 and 8. sel=3 throughout.
- Full rotation: req=8'hFF held, MAX_BURST=4 -> sel sequence is 0,1,2,...,7,0 with each owner for exactly 4 cycles. There are no idle cycles, and done pulses every 4 cycles.
- Early drop and wrap: ptr=7 with req=8'h81 -> req[7] is granted first. Drop req[7] after 2 grant cycles -> release, done=1, and gnt=8'h01 on the next edge.
- Data path: owner sel=6, drive in=8'b0100_0000 then 8'b0000_0000 -> out=1 then 0. Toggling in[5] while owner is 6 leaves out unaffected.
- en and reset mid-burst: en falls in burst cycle 2 -> released at that edge, state IDLE, gnt=0, no grants while en=0. Separately, rst=1 in burst cycle 3 -> all outputs 0 and ptr=0 at the next edge.

Source files
------------

// File: rtl/rr_mux8_arbiter_if.sv
// Bundle for the shared 8:1 path: requester-side controls and data, plus the grant/mux results.
// The arbiter connects through the slave modport; the requester side uses master.
interface rr_mux8_arbiter_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       out;
  logic       done;

  modport master (
    output en, req, in,
    input  gnt, sel, valid, out, done
  );

  modport slave (
    input  en, req, in,
    output gnt, sel, valid, out, done
  );
endinterface

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter for one shared single-bit 8:1 mux path. It grants bounded bursts,
// rotates priority past the last owner, and forwards the owner's data bit combinationally.
module rr_mux8_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux8_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] ptr_q, ptr_d;
  logic       done_q, done_d;

  logic [3:0] pick_idle;
  logic [3:0] pick_rel;
  logic [2:0] rel_ptr;
  logic       release_now;

  // Returns {found, index}: the first requester at or after p, wrapping modulo 8.
  // Scanning from the far end lets the nearest hit overwrite the result last.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign rel_ptr     = sel_q + 3'd1;
  assign pick_idle   = pick(bus.req, ptr_q);
  assign pick_rel    = pick(bus.req, rel_ptr);
  assign release_now = !bus.req[sel_q] || (cnt_q == MAX_CNT) || !bus.en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
      cnt_q   <= 4'd0;
      ptr_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = 8'd0;
        if (bus.en && pick_idle[3]) begin
          state_d = GRANT;
          sel_d   = pick_idle[2:0];
          gnt_d   = 8'd1 << pick_idle[2:0];
          cnt_d   = 4'd1;
        end
      end
      GRANT: begin
        if (!release_now) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // The releasing owner now sits last in priority, so re-arbitrate from rel_ptr.
          ptr_d  = rel_ptr;
          done_d = 1'b1;
          if (bus.en && pick_rel[3]) begin
            sel_d = pick_rel[2:0];
            gnt_d = 8'd1 << pick_rel[2:0];
            cnt_d = 4'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.done  = done_q;
  assign bus.valid = (state_q == GRANT) && bus.req[sel_q];
  assign bus.out   = bus.valid && bus.in[sel_q];

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Scoreboard bench for rr_mux8_arbiter: a stimulus process drives inputs and queues the
// reference model's expectations, and a monitor process pops and compares after every edge.
module tb_rr_mux8_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux8_arbiter_if bus ();

  rr_mux8_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       chk_sel;
    logic       done;
    logic       valid;
    logic       out;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 when none), priority pointer and burst length so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  function automatic int search(input logic [7:0] rq, input int p);
    for (int k = 0; k < 8; k++)
      if (rq[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic apply(input logic r, input logic e, input logic [7:0] rq, input logic [7:0] d);
    exp_t x;
    logic done_e;
    @(negedge clk);
    rst     = r;
    bus.en  = e;
    bus.req = rq;
    bus.in  = d;
    done_e  = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      if (e && rq != 8'd0) begin
        m_owner = search(rq, m_ptr);
        m_cnt   = 1;
      end
    end else if (!rq[m_owner] || m_cnt == MAXB || !e) begin
      done_e = 1'b1;
      m_ptr  = (m_owner + 1) % 8;
      if (e && rq != 8'd0) begin
        m_owner = search(rq, m_ptr);
        m_cnt   = 1;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_cnt++;
    end
    x.gnt     = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
    x.sel     = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    x.chk_sel = r || (m_owner >= 0);
    x.done    = done_e;
    x.valid   = (m_owner >= 0) && rq[m_owner];
    x.out     = x.valid && d[m_owner];
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every edge that had stimulus queued is compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("gnt", bus.gnt, x.gnt);
        if (x.chk_sel) chk("sel", {5'd0, bus.sel}, {5'd0, x.sel});
        chk("done", {7'd0, bus.done}, {7'd0, x.done});
        chk("valid", {7'd0, bus.valid}, {7'd0, x.valid});
        chk("out", {7'd0, bus.out}, {7'd0, x.out});
      end
    end
  end

  initial begin
    logic [7:0] held;
    logic       en_r;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = 8'd0;
    bus.in  = 8'd0;

    // Reset with every requester asserted, then the first grant must go to requester 0.
    repeat (2) apply(1'b1, 1'b1, 8'hFF, 8'($urandom));
    apply(1'b0, 1'b1, 8'hFF, 8'($urandom));
    repeat (2) apply(1'b1, 1'b0, 8'h00, 8'h00);

    // Sole requester held: back-to-back re-grants with a done pulse every MAXB cycles.
    repeat (10) apply(1'b0, 1'b1, 8'h08, 8'($urandom));

    // Full rotation with every requester asserted.
    repeat (36) apply(1'b0, 1'b1, 8'hFF, 8'($urandom));

    // Wrap: pointer reaches 7 after owner 6 releases, then 0x81 grants 7 first; drop 7 early.
    repeat (2) apply(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (MAXB) apply(1'b0, 1'b1, 8'h40, 8'($urandom));
    repeat (2) apply(1'b0, 1'b1, 8'h81, 8'($urandom));
    repeat (3) apply(1'b0, 1'b1, 8'h01, 8'($urandom));

    // Data path through owner 6 with in[5] toggling.
    repeat (2) apply(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (MAXB) apply(1'b0, 1'b1, 8'h40, 8'b0110_0000);
    apply(1'b0, 1'b1, 8'h40, 8'b0100_0000);
    apply(1'b0, 1'b1, 8'h40, 8'b0010_0000);
    apply(1'b0, 1'b1, 8'h40, 8'b0000_0000);

    // en falls mid-burst, then reset mid-burst.
    repeat (2) apply(1'b0, 1'b1, 8'h24, 8'($urandom));
    repeat (3) apply(1'b0, 1'b0, 8'h24, 8'($urandom));
    repeat (3) apply(1'b0, 1'b1, 8'h24, 8'($urandom));
    apply(1'b1, 1'b1, 8'h24, 8'($urandom));
    repeat (2) apply(1'b0, 1'b1, 8'h24, 8'($urandom));

    // Randomized held-level requests with occasional en drops and resets.
    held = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) held[b] = ~held[b];
      en_r = ($urandom_range(0, 15) != 0);
      apply(($urandom_range(0, 99) == 0), en_r, held, 8'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
